magnitude_comparator_serial: RTL

Parametrised, sequential successor to the 4-bit cascadable magnitude comparator. It compares two WIDTH-bit operands SLICE bits per clock, starting with the most significant slice, and stops early at the first unequal slice. Operands may be unsigned or two's-complement. The 74LS85-style cascade inputs resolve full equality, so wider comparisons chain the same way the 4-bit part does. It sits in the logic-design IP catalogue next to the combinational comparator and is used where operand width makes a single-cycle compare undesirable.

---
 rtl/magnitude_comparator_serial.sv | 112 +++++++++++
 1 files changed

// File: rtl/magnitude_comparator_serial.sv
// Serial magnitude comparator: compares WIDTH-bit operands SLICE bits per clock,
// MSB slice first, stopping at the first unequal slice; cascade inputs resolve ties.
module magnitude_comparator_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             igt,
   input  logic             ilt,
   input  logic             ieq,
   output logic             busy,
   output logic             done,
   output logic             ogt,
   output logic             olt,
   output logic             oeq
);
   localparam int NSLICES = WIDTH / SLICE;
   localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   typedef enum logic {IDLE, COMPARE} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  a_q, a_n, b_q, b_n;
   logic [2:0]        casc_q, casc_n;
   logic [IDXW-1:0]   idx_q, idx_n;
   logic [2:0]        res_q, res_n;
   logic              done_n;
   logic [SLICE-1:0]  sa, sb;
   logic [WIDTH-1:0]  msb_mask;

   // Flipping the sign bit turns two's-complement order into plain unsigned order.
   assign msb_mask = WIDTH'(signed_mode) << (WIDTH - 1);
   assign sa       = a_q[idx_q*SLICE +: SLICE];
   assign sb       = b_q[idx_q*SLICE +: SLICE];

   // {gt,lt,eq} cascade behaviour of the 4-bit part on full equality.
   function automatic logic [2:0] resolve(input logic [2:0] c);
      if (c[0])
         return 3'b001;
      case (c[2:1])
         2'b10:   return 3'b100;
         2'b01:   return 3'b010;
         2'b11:   return 3'b000;
         default: return 3'b110;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         casc_q <= '0;
         idx_q  <= '0;
         res_q  <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         a_q    <= a_n;
         b_q    <= b_n;
         casc_q <= casc_n;
         idx_q  <= idx_n;
         res_q  <= res_n;
         done   <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a_q;
      b_n     = b_q;
      casc_n  = casc_q;
      idx_n   = idx_q;
      res_n   = res_q;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               a_n     = a ^ msb_mask;
               b_n     = b ^ msb_mask;
               casc_n  = {igt, ilt, ieq};
               idx_n   = IDXW'(NSLICES - 1);
               state_n = COMPARE;
            end
         end
         COMPARE: begin
            if (sa != sb) begin
               res_n   = {sa > sb, sa < sb, 1'b0};
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (idx_q == '0) begin
               res_n   = resolve(casc_q);
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               idx_n = idx_q - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == COMPARE);
   assign ogt  = res_q[2];
   assign olt  = res_q[1];
   assign oeq  = res_q[0];
endmodule
